// File: rtl/cla_pkg.sv
// Shared constants and types for the 16-bit two-level carry-lookahead adder.
package cla_pkg;

  localparam int ADD_WIDTH   = 16;
  localparam int SLICE_WIDTH = 4;
  localparam int NUM_SLICES  = 4;

  typedef logic [ADD_WIDTH-1:0] add_word_t;

  // Everything the output stage captures for one accepted operand pair.
  typedef struct packed {
    add_word_t sum;
    logic      c_out;
    logic      p_out;
    logic      g_out;
  } add_result_t;

  // Two-level lookahead term: carry out of a group given its propagate,
  // generate and carry-in.
  function automatic logic group_carry(input logic grp_p, input logic grp_g,
                                       input logic cin);
    return grp_g | (grp_p & cin);
  endfunction

endpackage

// File: rtl/cla_4bit_slice.sv
// One 4-bit carry-lookahead slice: flattened internal carries from cin,
// plus group propagate/generate for the second-level lookahead unit.
module cla_4bit_slice
  import cla_pkg::*;
(
  input  logic [SLICE_WIDTH-1:0] a,
  input  logic [SLICE_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [SLICE_WIDTH-1:0] s,
  output logic                   P,
  output logic                   G
);

  logic [SLICE_WIDTH-1:0] p;
  logic [SLICE_WIDTH-1:0] g;
  logic [SLICE_WIDTH-1:0] c;

  // Bit-level propagate and generate.
  generate
    for (genvar gi = 0; gi < SLICE_WIDTH; gi++) begin : g_bit_pg
      assign p[gi] = a[gi] ^ b[gi];
      assign g[gi] = a[gi] & b[gi];
    end
  endgenerate

  // Group terms depend only on a/b, never on cin, so the LCU can use them
  // without waiting for any carry.
  assign P = &p;
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);

  // Internal carries expanded as sums of products straight from cin (no ripple).
  always_comb begin
    c    = '0;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
  end

  // Sum bits.
  assign s = p ^ c;

endmodule

// File: rtl/cla_16bit_with_lcu.sv
// 16-bit adder built from four 4-bit lookahead slices and a second-level
// lookahead carry unit; operands are captured and the result registered,
// giving one-cycle latency and one result per cycle when in_valid stays high.
module cla_16bit_with_lcu
  import cla_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADD_WIDTH-1:0] in1,
  input  logic [ADD_WIDTH-1:0] in2,
  input  logic                 c_in,
  input  logic                 in_valid,
  output logic [ADD_WIDTH-1:0] sum,
  output logic                 c_out,
  output logic                 p_out,
  output logic                 g_out,
  output logic                 out_valid
);

  logic [NUM_SLICES-1:0] slice_p;
  logic [NUM_SLICES-1:0] slice_g;
  logic [NUM_SLICES-1:0] slice_cin;
  logic                  carry_16;
  add_word_t             sum_comb;

  add_result_t result_next;
  add_result_t result_reg;
  logic        valid_reg;

  // Four identical slices; each takes its carry-in from the LCU.
  generate
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
      cla_4bit_slice u_slice (
        .a   (in1[gi*SLICE_WIDTH +: SLICE_WIDTH]),
        .b   (in2[gi*SLICE_WIDTH +: SLICE_WIDTH]),
        .cin (slice_cin[gi]),
        .s   (sum_comb[gi*SLICE_WIDTH +: SLICE_WIDTH]),
        .P   (slice_p[gi]),
        .G   (slice_g[gi])
      );
    end
  endgenerate

  // Second-level lookahead: every slice carry-in is a flat sum of products
  // of c_in and the slice P/G terms, so no carry crosses more than one level.
  always_comb begin
    slice_cin    = '0;
    slice_cin[0] = c_in;
    slice_cin[1] = group_carry(slice_p[0], slice_g[0], c_in);
    slice_cin[2] = slice_g[1]
                 | (slice_p[1] & slice_g[0])
                 | (slice_p[1] & slice_p[0] & c_in);
    slice_cin[3] = slice_g[2]
                 | (slice_p[2] & slice_g[1])
                 | (slice_p[2] & slice_p[1] & slice_g[0])
                 | (slice_p[2] & slice_p[1] & slice_p[0] & c_in);
  end

  // Carry out of bit 15 and the 16-bit group terms used for 32-bit cascading.
  always_comb begin
    result_next       = '0;
    carry_16          = slice_g[3]
                      | (slice_p[3] & slice_g[2])
                      | (slice_p[3] & slice_p[2] & slice_g[1])
                      | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
                      | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & c_in);
    result_next.sum   = sum_comb;
    result_next.c_out = carry_16;
    result_next.p_out = &slice_p;
    result_next.g_out = slice_g[3]
                      | (slice_p[3] & slice_g[2])
                      | (slice_p[3] & slice_p[2] & slice_g[1])
                      | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0]);
  end

  // Output stage: reset clears everything and drops any in-flight result;
  // otherwise the result loads only on an accepted pair and holds when idle,
  // so unknown operands during idle cycles never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        result_reg <= result_next;
      end
    end
  end

  assign sum       = result_reg.sum;
  assign c_out     = result_reg.c_out;
  assign p_out     = result_reg.p_out;
  assign g_out     = result_reg.g_out;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_cla_16bit_with_lcu.sv
// Self-checking bench for cla_16bit_with_lcu: directed corner cases, a random
// back-to-back sweep against an arithmetic reference, hold and reset checks.
module tb_cla_16bit_with_lcu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        c_in;
  logic        in_valid;
  logic [15:0] sum;
  logic        c_out;
  logic        p_out;
  logic        g_out;
  logic        out_valid;

  int n_checks = 0;
  int n_errors = 0;

  cla_16bit_with_lcu dut (
    .clk       (clk),
    .rst       (rst),
    .in1       (in1),
    .in2       (in2),
    .c_in      (c_in),
    .in_valid  (in_valid),
    .sum       (sum),
    .c_out     (c_out),
    .p_out     (p_out),
    .g_out     (g_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Expected outputs computed with plain integer arithmetic.
  logic [15:0] exp_sum;
  logic        exp_c;
  logic        exp_p;
  logic        exp_g;

  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [16:0] full;
    logic [16:0] no_cin;
    full    = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    no_cin  = {1'b0, a} + {1'b0, b};
    exp_sum = full[15:0];
    exp_c   = full[16];
    exp_p   = ((a ^ b) == 16'hFFFF);  // a carry-in would travel all 16 bits
    exp_g   = no_cin[16];             // carry out regardless of carry-in
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_result(input string tag, input logic ev);
    check({tag, " sum"},       {16'd0, sum},   {16'd0, exp_sum});
    check({tag, " c_out"},     {31'd0, c_out}, {31'd0, exp_c});
    check({tag, " p_out"},     {31'd0, p_out}, {31'd0, exp_p});
    check({tag, " g_out"},     {31'd0, g_out}, {31'd0, exp_g});
    check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ev});
  endtask

  // Drive one operand pair, clock it in, and look just after the edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic v);
    in1      = a;
    in2      = b;
    c_in     = ci;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci);
    issue(a, b, ci, 1'b1);
    model(a, b, ci);
    check_result(tag, 1'b1);
    $display("%s: %h + %h + %0d -> sum=%h c=%0d p=%0d g=%0d v=%0d",
             tag, a, b, ci, sum, c_out, p_out, g_out, out_valid);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    rst = 1'b1; in1 = '0; in2 = '0; c_in = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_sum = '0; exp_c = 1'b0; exp_p = 1'b0; exp_g = 1'b0;
    check_result("reset", 1'b0);
    $display("reset: sum=%h c=%0d p=%0d g=%0d v=%0d", sum, c_out, p_out, g_out, out_valid);
    rst = 1'b0;

    directed("add_1_2",       16'h0001, 16'h0002, 1'b0);
    directed("wrap_ffff_1",   16'hFFFF, 16'h0001, 1'b0);
    directed("prop_chain",    16'hFFFF, 16'h0000, 1'b1);
    directed("slice_cross",   16'h0FFF, 16'h0001, 1'b0);
    directed("slice1_cross",  16'h00FF, 16'h0001, 1'b0);
    directed("all_ones_cin",  16'hFFFF, 16'hFFFF, 1'b1);
    directed("alt_prop_cin",  16'hAAAA, 16'h5555, 1'b1);
    directed("alt_prop_nc",   16'hAAAA, 16'h5555, 1'b0);

    // Random back-to-back sweep: a fresh pair every cycle, no bubbles.
    for (int i = 0; i < 1200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i % 7 == 0) rb = ~ra;  // bias toward long propagate chains
      issue(ra, rb, rc, 1'b1);
      model(ra, rb, rc);
      check_result("random", 1'b1);
      $display("random %0d: %h + %h + %0d -> sum=%h c=%0d p=%0d g=%0d",
               i, ra, rb, rc, sum, c_out, p_out, g_out);
    end

    // Hold: an idle cycle with different (even unknown) operands changes nothing.
    directed("hold_load", 16'h1234, 16'h1111, 1'b0);
    issue(16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
    model(16'h1234, 16'h1111, 1'b0);
    check_result("hold_idle", 1'b0);
    $display("hold_idle: sum=%h v=%0d", sum, out_valid);
    issue(16'hxxxx, 16'hxxxx, 1'bx, 1'b0);
    check_result("hold_x", 1'b0);
    $display("hold_x: sum=%h v=%0d", sum, out_valid);

    // Reset wins over in_valid and drops the pending result.
    rst = 1'b1;
    issue(16'h7777, 16'h8888, 1'b1, 1'b1);
    exp_sum = '0; exp_c = 1'b0; exp_p = 1'b0; exp_g = 1'b0;
    check_result("reset_prio", 1'b0);
    $display("reset_prio: sum=%h c=%0d p=%0d g=%0d v=%0d", sum, c_out, p_out, g_out, out_valid);
    rst = 1'b0;

    // Recovery after reset.
    directed("after_reset", 16'h8000, 16'h8000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
